// File: rtl/load_extend_unit.sv
// Load lane-select and zero/sign-extend unit feeding register writeback through a small FIFO.
// Each result byte comes from its own lane cell working on the offset-shifted read word.

module load_extend_lane (
    input  logic       err,
    input  logic       in_range,
    input  logic       fill,
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);
    always_comb begin
        if (err)           byte_out = 8'h00;
        else if (in_range) byte_out = byte_in;
        else               byte_out = {8{fill}};
    end
endmodule

module load_extend_unit #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    parameter  int TAG_W  = 5,
    parameter  int CNT_W  = 8,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_cnt_clr
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int PTR_W     = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } entry_t;

    logic [DATA_W-1:0]         shifted;
    logic [NUM_LANES-1:0][7:0] lane_in;
    logic [NUM_LANES-1:0][7:0] lane_out;
    logic                      sign_bit;
    logic                      misaligned;
    entry_t                    new_entry;
    entry_t                    mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [PTR_W:0]            count;
    logic                      full, empty, push, pop;

    // Bring the addressed byte down to lane 0; lanes above the access width get the fill.
    assign shifted = in_data >> {in_offset, 3'b000};
    assign lane_in = shifted;

    always_comb begin
        misaligned = 1'b0;
        sign_bit   = shifted[7];
        case (in_size)
            2'b00: ;
            2'b01: begin
                misaligned = in_offset[0];
                sign_bit   = shifted[15];
            end
            2'b10: begin
                misaligned = |in_offset[1:0];
                sign_bit   = shifted[31];
            end
            default: begin
                misaligned = (|in_offset) || (DATA_W == 32);
                sign_bit   = shifted[DATA_W-1];
            end
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [3:0] LANE = 4'(i);
        load_extend_lane u_lane (
            .err      (misaligned),
            .in_range (LANE < (4'd1 << in_size)),
            .fill     (in_signed & sign_bit),
            .byte_in  (lane_in[i]),
            .byte_out (lane_out[i])
        );
    end

    assign new_entry.data = lane_out;
    assign new_entry.tag  = in_tag;
    assign new_entry.err  = misaligned;

    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign out_data = mem[rd_ptr].data;
    assign out_tag  = mem[rd_ptr].tag;
    assign out_err  = mem[rd_ptr].err;

    // Counted at acceptance so stalled consumers do not delay the statistic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt <= '0;
        else if (err_cnt_clr)
            err_cnt <= '0;
        else if (push && misaligned && (err_cnt != {CNT_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_load_extend_unit.sv
// Bench for load_extend_unit: a 32-bit (CNT_W=2) and a 64-bit instance, each tracked by a
// queue-based reference model and compared every cycle, plus directed literal expectations.

module tb_load_extend_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- 32-bit instance ----------------
    logic        a_rst, a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_err, a_clr;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_in_offset, a_in_size, a_err_cnt;
    logic [4:0]  a_in_tag, a_out_tag;

    load_extend_unit #(.DATA_W(32), .DEPTH(2), .TAG_W(5), .CNT_W(2)) u_a (
        .clk(clk), .reset(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_offset(a_in_offset), .in_size(a_in_size),
        .in_signed(a_in_signed), .in_tag(a_in_tag), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag),
        .out_err(a_out_err), .err_cnt(a_err_cnt), .err_cnt_clr(a_clr)
    );

    // ---------------- 64-bit instance ----------------
    logic        b_rst, b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_err, b_clr;
    logic [63:0] b_in_data, b_out_data;
    logic [2:0]  b_in_offset;
    logic [1:0]  b_in_size;
    logic [4:0]  b_in_tag, b_out_tag;
    logic [7:0]  b_err_cnt;

    load_extend_unit #(.DATA_W(64), .DEPTH(2), .TAG_W(5), .CNT_W(8)) u_b (
        .clk(clk), .reset(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_offset(b_in_offset), .in_size(b_in_size),
        .in_signed(b_in_signed), .in_tag(b_in_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag),
        .out_err(b_out_err), .err_cnt(b_err_cnt), .err_cnt_clr(b_clr)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    // Returns {err, data}: arithmetic lane select and extension straight from the access rules.
    function automatic logic [64:0] model_ext(input int dw, input logic [63:0] d, input int off,
                                              input int size, input logic sgn);
        int          w;
        logic [63:0] field;
        logic        err;
        w   = 8 << size;
        err = (size == 1 && off % 2 != 0) || (size == 2 && off % 4 != 0) ||
              (size == 3 && (off != 0 || dw == 32));
        if (err) return {1'b1, 64'd0};
        field = d >> (8 * off);
        if (w < 64) field = field & ((64'd1 << w) - 64'd1);
        if (sgn && w < dw && field[w-1]) field = field | (~64'd0 << w);
        if (dw == 32) field = field & 64'h0000_0000_FFFF_FFFF;
        return {1'b0, field};
    endfunction

    exp_t        qa[$], qb[$];
    int          cnt_a = 0, cnt_b = 0, na, nb;
    logic [64:0] ra, rb;

    always @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            qa.delete();
            cnt_a = 0;
        end else begin
            na = qa.size();
            ra = model_ext(32, 64'(a_in_data), int'(a_in_offset), int'(a_in_size), a_in_signed);
            if (a_out_ready && na > 0) void'(qa.pop_front());
            if (a_in_valid && na < 2) qa.push_back('{ra[63:0], a_in_tag, ra[64]});
            if (a_clr) cnt_a = 0;
            else if (a_in_valid && na < 2 && ra[64] && cnt_a < 3) cnt_a++;
        end
    end

    always @(posedge clk or posedge b_rst) begin
        if (b_rst) begin
            qb.delete();
            cnt_b = 0;
        end else begin
            nb = qb.size();
            rb = model_ext(64, b_in_data, int'(b_in_offset), int'(b_in_size), b_in_signed);
            if (b_out_ready && nb > 0) void'(qb.pop_front());
            if (b_in_valid && nb < 2) qb.push_back('{rb[63:0], b_in_tag, rb[64]});
            if (b_clr) cnt_b = 0;
            else if (b_in_valid && nb < 2 && rb[64] && cnt_b < 255) cnt_b++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!a_rst) begin
            check("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
            check("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
            check("a_err_cnt", 64'(a_err_cnt), 64'(cnt_a));
            if (qa.size() != 0) begin
                check("a_out_data", 64'(a_out_data), qa[0].data);
                check("a_out_tag", 64'(a_out_tag), 64'(qa[0].tag));
                check("a_out_err", 64'(a_out_err), 64'(qa[0].err));
            end
        end
        if (!b_rst) begin
            check("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
            check("b_in_ready", 64'(b_in_ready), 64'(qb.size() < 2));
            check("b_err_cnt", 64'(b_err_cnt), 64'(cnt_b));
            if (qb.size() != 0) begin
                check("b_out_data", b_out_data, qb[0].data);
                check("b_out_tag", 64'(b_out_tag), 64'(qb[0].tag));
                check("b_out_err", 64'(b_out_err), 64'(qb[0].err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic a_push(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                          input logic sg, input logic [4:0] tag);
        a_in_data = d; a_in_offset = off; a_in_size = sz; a_in_signed = sg; a_in_tag = tag;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_push(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                          input logic sg, input logic [4:0] tag);
        b_in_data = d; b_in_offset = off; b_in_size = sz; b_in_signed = sg; b_in_tag = tag;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    logic [1:0] bad_off [5] = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd0};
    logic [1:0] bad_sz  [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

    initial begin
        a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_offset = '0; a_in_size = '0;
        a_in_signed = 1'b0; a_in_tag = '0; a_out_ready = 1'b1; a_clr = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_offset = '0; b_in_size = '0;
        b_in_signed = 1'b0; b_in_tag = '0; b_out_ready = 1'b1; b_clr = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_tag", 64'(a_out_tag), 64'd0);
        check("rst_out_err", 64'(a_out_err), 64'd0);
        check("rst_err_cnt", 64'(a_err_cnt), 64'd0);
        #2 a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);

        // Byte sign/zero extension
        a_push(32'h1284_5678, 2'd2, 2'd0, 1'b1, 5'd1);
        @(negedge clk);
        check("t1_byte_signed", 64'(a_out_data), 64'hFFFF_FF84);
        check("t1_byte_err", 64'(a_out_err), 64'd0);
        a_push(32'h1284_5678, 2'd2, 2'd0, 1'b0, 5'd2);
        @(negedge clk);
        check("t1_byte_unsigned", 64'(a_out_data), 64'h0000_0084);

        // Half / word alignment
        a_push(32'h8001_7FFE, 2'd2, 2'd1, 1'b1, 5'd3);
        @(negedge clk);
        check("t2_half_signed", 64'(a_out_data), 64'hFFFF_8001);
        a_push(32'h8001_7FFE, 2'd1, 2'd1, 1'b1, 5'd4);
        @(negedge clk);
        check("t2_misalign_err", 64'(a_out_err), 64'd1);
        check("t2_misalign_data", 64'(a_out_data), 64'd0);
        check("t2_misalign_tag", 64'(a_out_tag), 64'd4);
        check("t2_err_cnt", 64'(a_err_cnt), 64'd1);
        a_push(32'h8001_7FFE, 2'd0, 2'd2, 1'b1, 5'd5);
        @(negedge clk);
        check("t2_word", 64'(a_out_data), 64'h8001_7FFE);
        @(negedge clk);

        // Backpressure
        a_out_ready = 1'b0;
        a_push(32'h0000_0011, 2'd0, 2'd0, 1'b0, 5'd1);
        a_push(32'h0000_0022, 2'd0, 2'd0, 1'b0, 5'd2);
        a_in_data = 32'h0000_0033; a_in_offset = 2'd0; a_in_size = 2'd0; a_in_signed = 1'b0;
        a_in_tag = 5'd3; a_in_valid = 1'b1;
        @(negedge clk);
        check("t3_full_in_ready", 64'(a_in_ready), 64'd0);
        check("t3_head_tag", 64'(a_out_tag), 64'd1);
        check("t3_head_data", 64'(a_out_data), 64'h11);
        @(negedge clk);
        check("t3_stall_data", 64'(a_out_data), 64'h11);
        check("t3_stall_tag", 64'(a_out_tag), 64'd1);
        a_out_ready = 1'b1;
        @(negedge clk);
        check("t3_pop1_tag", 64'(a_out_tag), 64'd2);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("t3_tag3_tag", 64'(a_out_tag), 64'd3);
        check("t3_tag3_data", 64'(a_out_data), 64'h33);

        // Counter clear, saturation, clear-over-increment
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        check("t4_clr", 64'(a_err_cnt), 64'd0);
        for (int i = 0; i < 5; i++) a_push(32'hCAFE_F00D, bad_off[i], bad_sz[i], 1'b1, 5'(6 + i));
        @(negedge clk);
        check("t4_saturate", 64'(a_err_cnt), 64'd3);
        a_clr = 1'b1;
        a_push(32'hCAFE_F00D, 2'd1, 2'd1, 1'b0, 5'd11);
        a_clr = 1'b0;
        @(negedge clk);
        check("t4_clr_priority", 64'(a_err_cnt), 64'd0);
        check("t4_err_entry", 64'(a_out_err), 64'd1);
        @(negedge clk);

        // Reset mid-operation
        a_out_ready = 1'b0;
        a_push(32'h0000_00AB, 2'd0, 2'd0, 1'b0, 5'd10);
        a_push(32'h0000_00AB, 2'd1, 2'd1, 1'b0, 5'd11);
        @(negedge clk);
        check("t6_pre_valid", 64'(a_out_valid), 64'd1);
        check("t6_pre_cnt", 64'(a_err_cnt), 64'd1);
        #2 a_rst = 1'b1;
        #1;
        check("t6_async_valid", 64'(a_out_valid), 64'd0);
        check("t6_async_cnt", 64'(a_err_cnt), 64'd0);
        check("t6_async_data", 64'(a_out_data), 64'd0);
        @(negedge clk);
        #2 a_rst = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        check("t6_post_ready", 64'(a_in_ready), 64'd1);
        a_push(32'h1284_5678, 2'd3, 2'd0, 1'b1, 5'd12);
        @(negedge clk);
        check("t6_post_data", 64'(a_out_data), 64'h12);
        check("t6_post_tag", 64'(a_out_tag), 64'd12);

        // 64-bit datapath
        b_push(64'hFEDC_BA98_7654_3210, 3'd4, 2'd2, 1'b1, 5'd1);
        @(negedge clk);
        check("t5_word_signed", b_out_data, 64'hFFFF_FFFF_FEDC_BA98);
        b_push(64'hFEDC_BA98_7654_3210, 3'd0, 2'd3, 1'b1, 5'd2);
        @(negedge clk);
        check("t5_dword", b_out_data, 64'hFEDC_BA98_7654_3210);
        b_push(64'hFEDC_BA98_7654_3210, 3'd4, 2'd3, 1'b0, 5'd3);
        @(negedge clk);
        check("t5_dword_misalign", 64'(b_out_err), 64'd1);
        check("t5_dword_misalign_data", b_out_data, 64'd0);
        check("t5_err_cnt", 64'(b_err_cnt), 64'd1);
        b_push(64'hFEDC_BA98_7654_3210, 3'd7, 2'd0, 1'b1, 5'd4);
        @(negedge clk);
        check("t5_byte7_signed", b_out_data, 64'hFFFF_FFFF_FFFF_FFFE);
        b_push(64'hFEDC_BA98_7654_3210, 3'd6, 2'd1, 1'b0, 5'd5);
        @(negedge clk);
        check("t5_half_unsigned", b_out_data, 64'h0000_0000_0000_FEDC);
        b_push(64'hFEDC_BA98_7654_3210, 3'd4, 2'd2, 1'b0, 5'd6);
        @(negedge clk);
        check("t5_word_unsigned", b_out_data, 64'h0000_0000_FEDC_BA98);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
